// File: rtl/mem_arbiter_n.sv
// Multi-port memory arbiter: grants one requester at a time and turns its
// request into a cache-block read burst or a single write beat on the bus.
module mem_arbiter_n #(
   parameter int NUM_PORTS  = 2,
   parameter int BLOCK_SIZE = 32,
   parameter int ARB_MODE   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_PORTS*32-1:0] req_addr,
   input  logic [NUM_PORTS-1:0]    req_read,
   input  logic [NUM_PORTS-1:0]    req_write,
   input  logic [NUM_PORTS*32-1:0] req_wdata,
   input  logic [NUM_PORTS*3-1:0]  req_strobe,
   output logic [BLOCK_SIZE*8-1:0] rd_data,
   output logic [NUM_PORTS-1:0]    done,
   output logic [NUM_PORTS-1:0]    busy,
   output logic [31:0]             addr,
   output logic                    write,
   output logic [31:0]             wdata,
   output logic [2:0]              transfer,
   output logic                    valid,
   input  logic [31:0]             rdata,
   input  logic                    ready
);

   localparam int BEATS = BLOCK_SIZE / 4;
   localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [31:0] BLK_MASK = ~32'(BLOCK_SIZE - 1);
   localparam logic [IW-1:0] LAST_PORT = IW'(NUM_PORTS - 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ_BURST,
      WRITE_BEAT,
      DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           gnt_q, gnt_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [31:0]             addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [2:0]              strb_q, strb_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BLOCK_SIZE*8-1:0] rd_q;
   logic [NUM_PORTS-1:0]    req_any;
   logic                    found;
   logic [IW-1:0]           pick;
   int                      cand;

   assign req_any = req_read | req_write;

   // Round-robin rotates the search start; fixed mode always starts at 0.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = (ARB_MODE == 0) ? k : int'(ptr_q) + k;
         if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
         if (!found && req_any[IW'(cand)]) begin
            found = 1'b1;
            pick  = IW'(cand);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d   = pick;
               ptr_d   = (pick == LAST_PORT) ? '0 : pick + IW'(1);
               addr_d  = req_addr[pick*32 +: 32];
               wdata_d = req_wdata[pick*32 +: 32];
               strb_d  = req_strobe[pick*3 +: 3];
               cnt_d   = '0;
               // a pending write beats a pending read on the same port
               state_d = req_write[pick] ? WRITE_BEAT : READ_BURST;
            end
         end
         READ_BURST: begin
            if (ready) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         WRITE_BEAT: begin
            if (ready) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         cnt_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         cnt_q   <= cnt_d;
         if (state_q == READ_BURST && ready) begin
            rd_q[cnt_q*32 +: 32] <= rdata;
         end
      end
   end

   // Beat outputs derive only from registered state, so they hold steady
   // across any number of wait states.
   always_comb begin
      valid    = 1'b0;
      write    = 1'b0;
      addr     = '0;
      wdata    = '0;
      transfer = 3'b000;
      unique case (state_q)
         READ_BURST: begin
            valid    = 1'b1;
            addr     = (addr_q & BLK_MASK) + (32'(cnt_q) << 2);
            transfer = 3'b010;
         end
         WRITE_BEAT: begin
            valid    = 1'b1;
            write    = 1'b1;
            addr     = addr_q;
            wdata    = wdata_q;
            transfer = strb_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      done = '0;
      if (state_q == DONE) done[gnt_q] = 1'b1;
   end

   assign busy    = req_any & ~done;
   assign rd_data = rd_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Randomised bench for mem_arbiter_n: a bus responder with wait states and a
// transaction-level arbitration model predict every grant, beat and block.
module tb_mem_arbiter_n;

   localparam int NP = 3;
   localparam int BS = 32;
   localparam int NB = BS / 4;

   typedef struct packed {
      logic [31:0] a;
      logic        w;
      logic [31:0] d;
      logic [2:0]  t;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [NP*32-1:0] req_addr, req_wdata;
   logic [NP-1:0]    req_read, req_write;
   logic [NP*3-1:0]  req_strobe;
   logic [BS*8-1:0]  rd_data;
   logic [NP-1:0]    done, busy;
   logic [31:0]      addr, wdata;
   logic [31:0]      rdata = '0;
   logic             write, valid;
   logic             ready = 1'b0;
   logic [2:0]       transfer;

   logic [63:0]  f_addr = '0;
   logic [63:0]  f_wdata = '0;
   logic [1:0]   f_rd = '0;
   logic [1:0]   f_wr = '0;
   logic [5:0]   f_strb = '0;
   logic [255:0] f_rdd;
   logic [1:0]   f_done, f_busy;
   logic [31:0]  f_baddr, f_bwdata;
   logic [31:0]  f_rdata = '0;
   logic         f_bw, f_bv;
   logic         f_ready = 1'b1;
   logic [2:0]   f_bt;

   mem_arbiter_n #(.NUM_PORTS(NP), .BLOCK_SIZE(BS), .ARB_MODE(1)) dut (
      .clk(clk), .rst(rst),
      .req_addr(req_addr), .req_read(req_read), .req_write(req_write),
      .req_wdata(req_wdata), .req_strobe(req_strobe),
      .rd_data(rd_data), .done(done), .busy(busy),
      .addr(addr), .write(write), .wdata(wdata), .transfer(transfer),
      .valid(valid), .rdata(rdata), .ready(ready)
   );

   mem_arbiter_n #(.NUM_PORTS(2), .BLOCK_SIZE(32), .ARB_MODE(0)) dut_fix (
      .clk(clk), .rst(rst),
      .req_addr(f_addr), .req_read(f_rd), .req_write(f_wr),
      .req_wdata(f_wdata), .req_strobe(f_strb),
      .rd_data(f_rdd), .done(f_done), .busy(f_busy),
      .addr(f_baddr), .write(f_bw), .wdata(f_bwdata), .transfer(f_bt),
      .valid(f_bv), .rdata(f_rdata), .ready(f_ready)
   );

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] salt = 32'h1234_5678;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   beat_t         beats[$];
   logic [NP-1:0] dn_s = '0;
   logic [NP-1:0] bsy_s = '0;
   logic [1:0]    fdn_s = '0;
   logic          vld_s = 1'b0;
   int            wait_cfg = 0;
   bit            wait_rand = 0;
   int            stall = 0;
   int            tgt = 0;
   bit            pv = 0;
   bit            pr = 0;
   beat_t         pb, cur;
   event          mon_ev;

   // Bus responder and monitor: picks ready for the coming edge, logs
   // completing beats and checks that stalled beats hold still.
   always @(negedge clk) begin
      cur = '{a: addr, w: write, d: wdata, t: transfer};
      if (!rst) begin
         pv = 0;
         stall = 0;
         ready = 1'b0;
      end else begin
         if (pv && !pr) begin
            n_checks++;
            if (!valid || cur !== pb) begin
               n_fail++;
               $display("FAIL beat_stable: valid=%b beat=%h, required 1 %h",
                        valid, cur, pb);
            end
         end
         if (valid) begin
            if (stall == 0) tgt = wait_rand ? $urandom_range(0, 2) : wait_cfg;
            ready = (stall == tgt);
            if (ready) begin
               beats.push_back(cur);
               stall = 0;
            end else begin
               stall++;
            end
         end else begin
            ready = ($urandom_range(0, 1) == 1);
         end
         pv = valid;
         pr = ready;
         pb = cur;
      end
      rdata = (valid && !write) ? mem_f(addr) : 32'h0;
      dn_s = done;
      bsy_s = busy;
      fdn_s = f_done;
      vld_s = valid;
      -> mon_ev;
   end

   task automatic set_req(input int p, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] s);
      req_read[p] = rd;
      req_write[p] = wr;
      req_addr[p*32 +: 32] = a;
      req_wdata[p*32 +: 32] = d;
      req_strobe[p*3 +: 3] = s;
   endtask

   task automatic wait_done(input int bound, output logic [NP-1:0] got,
                            output int cyc);
      got = '0;
      cyc = 0;
      while (cyc < bound && got == '0) begin
         @(mon_ev);
         cyc++;
         got = dn_s;
      end
   endtask

   task automatic do_reset();
      req_read = '0;
      req_write = '0;
      rst = 1'b0;
      repeat (2) @(mon_ev);
      rst = 1'b1;
      @(mon_ev);
   endtask

   task automatic test_reset();
      repeat (2) @(mon_ev);
      n_checks++;
      if ({valid, write, addr, wdata, transfer} !== '0) begin
         n_fail++;
         $display("FAIL reset_bus: got %b %b %h %h %b, required all zero",
                  valid, write, addr, wdata, transfer);
      end
      n_checks++;
      if (done !== '0 || rd_data !== '0) begin
         n_fail++;
         $display("FAIL reset_done_rd: done=%b rd_data=%h, required 0",
                  done, rd_data);
      end
      n_checks++;
      if ({f_bv, f_bw, f_baddr, f_bt, f_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_fixed: got %b %b %h %b %b, required zero",
                  f_bv, f_bw, f_baddr, f_bt, f_done);
      end
      set_req(0, 1, 0, 32'h40, 0, 0);
      @(mon_ev);
      n_checks++;
      if (busy !== 3'b001 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: busy=%b valid=%b, required 001 0",
                  busy, valid);
      end
      req_read = '0;
      rst = 1'b1;
      @(mon_ev);
   endtask

   logic [BS*8-1:0] rd_keep;

   task automatic test_read_burst();
      logic [NP-1:0] got;
      int cyc;
      wait_rand = 0;
      wait_cfg = 0;
      salt = $urandom;
      beats.delete();
      set_req(0, 1, 0, 32'h104, 0, 0);
      wait_done(60, got, cyc);
      n_checks++;
      if (got !== 3'b001) begin
         n_fail++;
         $display("FAIL rd_done: done=%b, required 001", got);
      end
      n_checks++;
      if (cyc !== NB + 1) begin
         n_fail++;
         $display("FAIL rd_latency: %0d cycles, required %0d", cyc, NB + 1);
      end
      n_checks++;
      if (beats.size() !== NB) begin
         n_fail++;
         $display("FAIL rd_beats: %0d beats, required %0d", beats.size(), NB);
      end
      for (int k = 0; k < NB && k < beats.size(); k++) begin
         n_checks++;
         if (beats[k].a !== 32'h100 + 32'(4 * k) || beats[k].w !== 1'b0 ||
             beats[k].t !== 3'b010) begin
            n_fail++;
            $display("FAIL rd_beat%0d: addr=%h w=%b t=%b, required %h 0 010",
                     k, beats[k].a, beats[k].w, beats[k].t,
                     32'h100 + 32'(4 * k));
         end
      end
      for (int k = 0; k < NB; k++) begin
         n_checks++;
         if (rd_data[k*32 +: 32] !== mem_f(32'h100 + 32'(4 * k))) begin
            n_fail++;
            $display("FAIL rd_word%0d: %h, required %h", k,
                     rd_data[k*32 +: 32], mem_f(32'h100 + 32'(4 * k)));
         end
      end
      req_read = '0;
      rd_keep = rd_data;
      @(mon_ev);
      n_checks++;
      if (dn_s !== '0 || rd_data !== rd_keep) begin
         n_fail++;
         $display("FAIL rd_pulse: done=%b rd_held=%b, required 000 1",
                  dn_s, rd_data === rd_keep);
      end
   endtask

   task automatic test_write_wait();
      int vcnt = 0;
      int cyc = 0;
      wait_cfg = 3;
      beats.delete();
      set_req(1, 0, 1, 32'h202, 32'hBEEF_0000, 3'b001);
      dn_s = '0;
      while (cyc < 40 && dn_s == '0) begin
         @(mon_ev);
         cyc++;
         if (vld_s) vcnt++;
      end
      n_checks++;
      if (dn_s !== 3'b010) begin
         n_fail++;
         $display("FAIL wr_done: done=%b, required 010", dn_s);
      end
      n_checks++;
      if (vcnt !== 4) begin
         n_fail++;
         $display("FAIL wr_hold: valid %0d cycles, required 4", vcnt);
      end
      n_checks++;
      if (beats.size() !== 1 ||
          beats[0] !== '{a: 32'h202, w: 1'b1, d: 32'hBEEF_0000, t: 3'b001})
      begin
         n_fail++;
         $display("FAIL wr_beat: n=%0d beat=%h, required 1 beat 202/1/BEEF0000/001",
                  beats.size(), beats.size() > 0 ? beats[0] : '0);
      end
      n_checks++;
      if (rd_data !== rd_keep) begin
         n_fail++;
         $display("FAIL wr_rd_held: %h, required %h", rd_data, rd_keep);
      end
      req_write = '0;
      wait_cfg = 0;
      @(mon_ev);
   endtask

   task automatic test_rr();
      logic [NP-1:0] got;
      int cyc;
      set_req(0, 1, 0, $urandom, 0, 0);
      set_req(1, 1, 0, $urandom, 0, 0);
      wait_done(60, got, cyc);
      n_checks++;
      if (got !== 3'b001) begin
         n_fail++;
         $display("FAIL rr_first: done=%b, required 001", got);
      end
      set_req(0, 1, 0, $urandom, 0, 0);
      @(mon_ev);
      n_checks++;
      if (vld_s !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_gap: valid=%b after done, required 0", vld_s);
      end
      wait_done(60, got, cyc);
      n_checks++;
      if (got !== 3'b010) begin
         n_fail++;
         $display("FAIL rr_second: done=%b, required 010", got);
      end
      req_read[1] = 1'b0;
      wait_done(60, got, cyc);
      n_checks++;
      if (got !== 3'b001) begin
         n_fail++;
         $display("FAIL rr_third: done=%b, required 001", got);
      end
      req_read = '0;
      @(mon_ev);
   endtask

   task automatic test_fixed();
      logic [1:0] got;
      int cyc;
      f_addr = {32'h0000_2000, 32'h0000_1000};
      f_rd = 2'b11;
      for (int i = 0; i < 4; i++) begin
         got = '0;
         cyc = 0;
         while (cyc < 40 && got == '0) begin
            @(mon_ev);
            cyc++;
            got = fdn_s;
         end
         n_checks++;
         if (got !== ((i == 3) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL fixed_grant%0d: done=%b, required %b", i, got,
                     (i == 3) ? 2'b10 : 2'b01);
         end
         if (i == 2) f_rd = 2'b10;
      end
      f_rd = '0;
      @(mon_ev);
   endtask

   task automatic test_rw_same();
      logic [NP-1:0] got;
      int cyc;
      logic [31:0] a, d;
      logic [2:0] s;
      a = $urandom;
      d = $urandom;
      s = 3'($urandom_range(0, 2));
      wait_cfg = 1;
      beats.delete();
      set_req(2, 1, 1, a, d, s);
      wait_done(60, got, cyc);
      n_checks++;
      if (got !== 3'b100 || beats.size() !== 1 ||
          beats[0] !== '{a: a, w: 1'b1, d: d, t: s}) begin
         n_fail++;
         $display("FAIL rw_write_first: done=%b n=%0d, required 100 and 1 write beat",
                  got, beats.size());
      end
      set_req(2, 1, 0, a, d, s);
      beats.delete();
      wait_done(60, got, cyc);
      n_checks++;
      if (got !== 3'b100 || beats.size() !== NB ||
          beats[0].a !== (a & ~32'(BS - 1)) || beats[0].w !== 1'b0) begin
         n_fail++;
         $display("FAIL rw_read_next: done=%b n=%0d, required 100 and %0d read beats",
                  got, beats.size(), NB);
      end
      req_read = '0;
      wait_cfg = 0;
      @(mon_ev);
   endtask

   task automatic test_reset_midburst();
      logic [NP-1:0] got;
      int cyc = 0;
      logic [31:0] a;
      a = $urandom;
      beats.delete();
      set_req(0, 1, 0, a, 0, 0);
      while (beats.size() < 4 && cyc < 40) begin
         @(mon_ev);
         cyc++;
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({valid, write, addr, wdata, transfer, done} !== '0 ||
          rd_data !== '0) begin
         n_fail++;
         $display("FAIL rst_async: valid=%b addr=%h done=%b rd0=%h, required 0",
                  valid, addr, done, rd_data[31:0]);
      end
      for (int i = 0; i < 3; i++) begin
         @(mon_ev);
         n_checks++;
         if (dn_s !== '0 || vld_s !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold%0d: done=%b valid=%b, required 0 0",
                     i, dn_s, vld_s);
         end
      end
      rst = 1'b1;
      beats.delete();
      wait_done(60, got, cyc);
      n_checks++;
      if (got !== 3'b001 || beats.size() !== NB ||
          beats[0].a !== (a & ~32'(BS - 1))) begin
         n_fail++;
         $display("FAIL rst_restart: done=%b n=%0d first=%h, required 001 %0d %h",
                  got, beats.size(), beats.size() > 0 ? beats[0].a : 32'h0,
                  NB, a & ~32'(BS - 1));
      end
      req_read = '0;
      @(mon_ev);
   endtask

   bit          rp[NP];
   bit          wp[NP];
   logic [31:0] pa[NP];
   logic [31:0] pd[NP];
   logic [2:0]  ps[NP];

   task automatic new_req(input int p);
      int r;
      r = $urandom_range(1, 3);
      rp[p] = (r != 2);
      wp[p] = (r != 1);
      pa[p] = $urandom;
      pd[p] = $urandom;
      ps[p] = 3'($urandom_range(0, 2));
      set_req(p, rp[p], wp[p], pa[p], pd[p], ps[p]);
   endtask

   task automatic test_random(input int ntx);
      logic [NP-1:0] got, act;
      int cyc, ptr, win, nact;
      bit is_wr;
      logic [31:0] base;
      do_reset();
      wait_rand = 1;
      ptr = 0;
      for (int p = 0; p < NP; p++) begin
         rp[p] = 0;
         wp[p] = 0;
         if ($urandom_range(0, 1) == 1) new_req(p);
      end
      if (!(rp[0] | wp[0] | rp[1] | wp[1] | rp[2] | wp[2])) new_req(NP - 1);
      beats.delete();
      for (int t = 0; t < ntx; t++) begin
         win = -1;
         act = '0;
         for (int k = 0; k < NP; k++) begin
            if (rp[(ptr + k) % NP] || wp[(ptr + k) % NP]) begin
               if (win < 0) win = (ptr + k) % NP;
            end
            act[k] = rp[k] | wp[k];
         end
         is_wr = wp[win];
         base = pa[win] & ~32'(BS - 1);
         wait_done(100, got, cyc);
         n_checks++;
         if (got !== NP'(1 << win)) begin
            n_fail++;
            $display("FAIL rand_grant t%0d: done=%b, required port %0d",
                     t, got, win);
         end
         n_checks++;
         if (bsy_s !== (act & ~NP'(1 << win))) begin
            n_fail++;
            $display("FAIL rand_busy t%0d: busy=%b, required %b", t, bsy_s,
                     act & ~NP'(1 << win));
         end
         n_checks++;
         if (is_wr && (beats.size() !== 1 ||
             beats[0] !== '{a: pa[win], w: 1'b1, d: pd[win], t: ps[win]}))
         begin
            n_fail++;
            $display("FAIL rand_write t%0d: n=%0d beat=%h, required %h/1/%h/%b",
                     t, beats.size(), beats.size() > 0 ? beats[0] : '0,
                     pa[win], pd[win], ps[win]);
         end else if (!is_wr && beats.size() !== NB) begin
            n_fail++;
            $display("FAIL rand_read t%0d: %0d beats, required %0d",
                     t, beats.size(), NB);
         end
         for (int k = 0; !is_wr && k < beats.size(); k++) begin
            n_checks++;
            if (beats[k].a !== base + 32'(4 * k) || beats[k].w !== 1'b0 ||
                beats[k].t !== 3'b010 ||
                rd_data[k*32 +: 32] !== mem_f(base + 32'(4 * k))) begin
               n_fail++;
               $display("FAIL rand_rdbeat t%0d k%0d: addr=%h word=%h, required %h %h",
                        t, k, beats[k].a, rd_data[k*32 +: 32],
                        base + 32'(4 * k), mem_f(base + 32'(4 * k)));
            end
         end
         if (is_wr) wp[win] = 0;
         else rp[win] = 0;
         set_req(win, rp[win], wp[win], pa[win], pd[win], ps[win]);
         ptr = (win + 1) % NP;
         nact = 0;
         for (int p = 0; p < NP; p++) begin
            if (!rp[p] && !wp[p] && $urandom_range(0, 1) == 1) new_req(p);
            if (rp[p] || wp[p]) nact++;
         end
         if (nact == 0) new_req($urandom_range(0, NP - 1));
         beats.delete();
      end
      req_read = '0;
      req_write = '0;
      wait_rand = 0;
      @(mon_ev);
   endtask

   initial begin
      req_read = '0;
      req_write = '0;
      req_addr = '0;
      req_wdata = '0;
      req_strobe = '0;
      test_reset();
      test_read_burst();
      test_write_wait();
      test_rr();
      test_fixed();
      test_rw_same();
      test_reset_midburst();
      test_random(60);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
